// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 serial transmitter (LSB first, idle-high).
//
// Parameters
//   CLK_PER_BIT : clock cycles per serial bit (2..65535)
//   FIFO_DEPTH  : FIFO entries, power of two, >= 2
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   data_in  : byte to enqueue
//   wr_en    : one-cycle write strobe for data_in
//   tx       : serial line (registered)
//   full     : FIFO count == FIFO_DEPTH
//   empty    : FIFO count == 0
//   count    : FIFO occupancy 0..FIFO_DEPTH
//   overflow : one-cycle pulse the cycle after a write is dropped
//   tx_busy  : FSM not idle or FIFO not empty
module uart_tx_buffered #(
  parameter logic [15:0] CLK_PER_BIT = 16'd1250,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          wr_en,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   LAST_TICK = CLK_PER_BIT - 16'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shift, shift_next;
  logic [15:0]   bit_cnt, bit_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic          tx_next;
  logic          push, pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign tx_busy = (state != IDLE) || !empty;
  // full is the registered flag, so a pop in the same cycle cannot rescue a write.
  assign push    = wr_en && !full;

  // tx_next is the level for the upcoming bit period; tx itself is a flop so the
  // line changes on the same edge as the state.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    tx_next      = tx;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!empty) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr];
          bit_cnt_next = '0;
          tx_next      = 1'b0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_cnt == LAST_TICK) begin
          bit_cnt_next = '0;
          bit_idx_next = '0;
          tx_next      = shift[0];
          shift_next   = {1'b0, shift[7:1]};
          state_next   = DATA;
        end else begin
          bit_cnt_next = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_TICK) begin
          bit_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift[0];
            shift_next   = {1'b0, shift[7:1]};
          end
        end else begin
          bit_cnt_next = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_cnt == LAST_TICK) begin
          bit_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          bit_cnt_next = bit_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      tx       <= tx_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      bit_idx  <= bit_idx_next;
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; only entries written since reset are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= data_in;
  end

endmodule
